// File: rtl/eca_pkg.sv
// Shared types and helpers for the output-buffer read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eca_pkg;

  // Default width of the user read bus.
  localparam int OUT_DATA_W_DEFAULT = 32;

  // Reader control states: idle, waiting for FIFO read data, sending beats.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } rdr_state_t;

  // Number of user beats needed to carry one parity row.
  function automatic int beats_per_row(input int w, input int packet_length, input int out_data_w);
    return (w * packet_length) / out_data_w;
  endfunction

endpackage

// File: rtl/eca_outbuf_reader_if.sv
// User read stream: one beat per valid/ready handshake, framed with stripe sop/last.
// Latency: n/a (wires only).
// Backpressure: master holds data/sop/last while out_valid=1 and out_ready=0.
interface eca_outbuf_reader_if #(
  parameter int OUT_DATA_W = eca_pkg::OUT_DATA_W_DEFAULT
);
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_DATA_W-1:0] out_data;
  logic                  out_sop;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_sop,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/eca_row_serializer.sv
// Row shift register: loads one parity row and presents it LSB-first, one beat at a time.
// Latency: loaded word visible on out_data the cycle after load.
// Backpressure: contents and beat count only advance on shift, so a stalled beat is held.
module eca_row_serializer #(
  parameter int ROW_W      = 256,
  parameter int OUT_DATA_W = 32,
  parameter int BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [ROW_W-1:0]      load_data,
  input  logic                  shift,
  output logic [OUT_DATA_W-1:0] out_data,
  output logic                  first_beat,
  output logic                  last_beat
);
  localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [ROW_W-1:0] sreg_q;
  logic [BC_W-1:0]  beat_cnt_q;

  assign out_data   = sreg_q[OUT_DATA_W-1:0];
  assign first_beat = (beat_cnt_q == '0);
  assign last_beat  = (beat_cnt_q == BC_W'(BEATS - 1));

  // Capture a fresh row, or drop the accepted beat off the bottom and count it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg_q     <= '0;
      beat_cnt_q <= '0;
    end else if (load) begin
      sreg_q     <= load_data;
      beat_cnt_q <= '0;
    end else if (shift) begin
      sreg_q     <= sreg_q >> OUT_DATA_W;
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/eca_outbuf_reader.sv
// Output-buffer reader: pops parity rows from the FIFO and serializes them as stripe-framed beats.
// Latency: rd_req at t, read data at t+1, first beat at t+2; BEATS+2 cycles per row with no stall.
// Backpressure: out_ready low holds the current beat; no new FIFO read until the row is drained.
module eca_outbuf_reader
  import eca_pkg::*;
#(
  parameter int PACKET_LENGTH = 32,
  parameter int W             = 8,
  parameter int OUT_DATA_W    = OUT_DATA_W_DEFAULT,
  parameter int M_MAX         = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [$clog2(M_MAX+1)-1:0]   m_val,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_req,
  input  logic [W*PACKET_LENGTH-1:0]   fifo_rd_data,
  input  logic                         fifo_rd_data_val,
  eca_outbuf_reader_if.master          out_if,
  output logic                         stripe_done,
  output logic                         err_unexp_val
);
  localparam int ROW_W = W * PACKET_LENGTH;
  localparam int BEATS = beats_per_row(W, PACKET_LENGTH, OUT_DATA_W);
  localparam int MW    = $clog2(M_MAX + 1);

  if ((W * PACKET_LENGTH) % OUT_DATA_W != 0) begin : g_width_check
    $error("W*PACKET_LENGTH must be an integer multiple of OUT_DATA_W");
  end

  rdr_state_t state_q, state_d;
  logic [MW-1:0] row_cnt_q;
  logic [MW-1:0] m_lat_q;
  logic [MW-1:0] m_eff;
  logic          rd_go;
  logic          load;
  logic          sending;
  logic          accept;
  logic          first_beat;
  logic          last_beat;
  logic          last_row;
  logic          row_end;
  logic          stripe_done_q;
  logic          err_q;

  // A stripe of zero rows makes no sense; treat it as a single-row stripe.
  assign m_eff    = (m_val == '0) ? MW'(1) : m_val;

  assign sending  = (state_q == SEND);
  assign accept   = sending & out_if.out_ready;
  assign last_row = (row_cnt_q == m_lat_q - 1'b1);
  assign row_end  = accept & last_beat;

  // Gated by rstn so the request reads low for the whole reset interval.
  assign fifo_rd_req      = rd_go & rstn;

  assign out_if.out_valid = sending;
  assign out_if.out_sop   = sending & first_beat & (row_cnt_q == '0);
  assign out_if.out_last  = sending & last_beat & last_row;
  assign stripe_done      = stripe_done_q;
  assign err_unexp_val    = err_q;

  eca_row_serializer #(
    .ROW_W      (ROW_W),
    .OUT_DATA_W (OUT_DATA_W),
    .BEATS      (BEATS)
  ) u_ser (
    .clk        (clk),
    .rstn       (rstn),
    .load       (load),
    .load_data  (fifo_rd_data),
    .shift      (accept),
    .out_data   (out_if.out_data),
    .first_beat (first_beat),
    .last_beat  (last_beat)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: one read per row, wait for its data, then drain every beat before reading again.
  always_comb begin
    state_d = state_q;
    rd_go   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          rd_go   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fifo_rd_data_val) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (row_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stripe position: latch the row count at the first read of a stripe, advance at each row end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt_q <= '0;
      m_lat_q   <= MW'(1);
    end else begin
      if (rd_go && row_cnt_q == '0) m_lat_q <= m_eff;
      if (row_end) row_cnt_q <= last_row ? '0 : row_cnt_q + 1'b1;
    end
  end

  // Stripe completion pulse and sticky flag for read data nobody asked for.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stripe_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      stripe_done_q <= row_end & last_row;
      if (fifo_rd_data_val && state_q != WAIT) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_eca_outbuf_reader.sv
// Bench for eca_outbuf_reader: FIFO responder, stripe-framing model and per-cycle compare.
// Latency: model expects the first beat of each row two cycles after its read request.
// Backpressure: out_ready patterns are driven from a table; held beats are checked for stability.
module tb_eca_outbuf_reader;
  localparam int PL    = 32;
  localparam int W     = 8;
  localparam int ODW   = 32;
  localparam int M_MAX = 4;
  localparam int ROW_W = W * PL;
  localparam int BEATS = ROW_W / ODW;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        last;
    int          first_cyc;
  } beat_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic [2:0]       m_val = 3'd1;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_req;
  logic [ROW_W-1:0] fifo_rd_data = '0;
  logic             fifo_rd_data_val = 1'b0;
  logic             stripe_done;
  logic             err_unexp_val;

  eca_outbuf_reader_if #(.OUT_DATA_W(ODW)) out_if ();

  eca_outbuf_reader #(
    .PACKET_LENGTH (PL),
    .W             (W),
    .OUT_DATA_W    (ODW),
    .M_MAX         (M_MAX)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .en               (en),
    .m_val            (m_val),
    .fifo_empty       (fifo_empty),
    .fifo_rd_req      (fifo_rd_req),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_data_val (fifo_rd_data_val),
    .out_if           (out_if),
    .stripe_done      (stripe_done),
    .err_unexp_val    (err_unexp_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t            exp_q[$];
  beat_t            acc_log[$];
  logic [ROW_W-1:0] fifo_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int req_cnt = 0;
  int last_req_cyc = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int inj_req = 0;
  bit force_empty = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] mkrow(input logic [31:0] base);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < W; i++) r[i*PL +: PL] = base + 32'(i);
    return r;
  endfunction

  // FIFO responder and stripe model: one read answered a cycle later, expected beats queued per row.
  initial begin
    bit               pend;
    logic [ROW_W-1:0] pend_word;
    int               model_row;
    int               model_m;
    int               inj_done;
    pend = 1'b0; pend_word = '0; model_row = 0; model_m = 1; inj_done = 0;
    out_if.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn && fifo_rd_req) begin
        req_cnt++;
        last_req_cyc = cyc;
        pend_word = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
        if (model_row == 0) model_m = (m_val == 3'd0) ? 1 : int'(m_val);
        for (int b = 0; b < BEATS; b++)
          exp_q.push_back('{d: pend_word[b*ODW +: ODW],
                            sop: (model_row == 0 && b == 0),
                            last: (model_row == model_m - 1 && b == BEATS - 1),
                            first_cyc: (b == 0) ? cyc + 2 : -1});
        model_row = (model_row + 1) % model_m;
        pend = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        pend = 1'b0;
        model_row = 0;
        exp_q.delete();
      end
      if (inj_req != inj_done) begin
        inj_done++;
        fifo_rd_data_val = 1'b1;
        fifo_rd_data = {8{32'hDEADBEEF}};
      end else begin
        fifo_rd_data_val = pend;
        fifo_rd_data = pend ? pend_word : '0;
      end
      pend = 1'b0;
      fifo_empty = force_empty || (fifo_q.size() == 0);
      case (ready_mode)
        1:       out_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_if.out_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every cycle checks reset values, beats against the model, holds and pulses.
  initial begin
    bit    prev_stall;
    bit    prev_last_acc;
    beat_t prev_b;
    beat_t e;
    prev_stall = 1'b0; prev_last_acc = 1'b0;
    prev_b = '{d: '0, sop: 1'b0, last: 1'b0, first_cyc: 0};
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_out_data", out_if.out_data, 32'd0);
        chk("rst_out_sop", 32'(out_if.out_sop), 32'd0);
        chk("rst_out_last", 32'(out_if.out_last), 32'd0);
        chk("rst_stripe_done", 32'(stripe_done), 32'd0);
        chk("rst_err", 32'(err_unexp_val), 32'd0);
        chk("rst_rd_req", 32'(fifo_rd_req), 32'd0);
        prev_stall = 1'b0;
        prev_last_acc = 1'b0;
      end else begin
        chk("stripe_done", 32'(stripe_done), 32'(prev_last_acc));
        if (stripe_done) done_cnt++;
        if (fifo_empty || !en) chk("rd_req_gated", 32'(fifo_rd_req), 32'd0);
        if (prev_stall) begin
          chk("hold_valid", 32'(out_if.out_valid), 32'd1);
          chk("hold_data", out_if.out_data, prev_b.d);
          chk("hold_sop", 32'(out_if.out_sop), 32'(prev_b.sop));
          chk("hold_last", 32'(out_if.out_last), 32'(prev_b.last));
        end
        prev_last_acc = 1'b0;
        if (out_if.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", 32'(out_if.out_valid), 32'd0);
          end else begin
            e = exp_q[0];
            chk("beat_data", out_if.out_data, e.d);
            chk("beat_sop", 32'(out_if.out_sop), 32'(e.sop));
            chk("beat_last", 32'(out_if.out_last), 32'(e.last));
            if (!prev_stall && e.first_cyc >= 0) chk("first_beat_latency", cyc, e.first_cyc);
            if (out_if.out_ready) begin
              void'(exp_q.pop_front());
              acc_log.push_back('{d: out_if.out_data, sop: out_if.out_sop,
                                  last: out_if.out_last, first_cyc: cyc});
              prev_last_acc = e.last;
            end
          end
        end
        prev_stall = out_if.out_valid && !out_if.out_ready;
        prev_b = '{d: out_if.out_data, sop: out_if.out_sop, last: out_if.out_last, first_cyc: 0};
      end
    end
  end

  task automatic wait_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc_log.size() < n && k < budget) begin
      @(posedge clk); #2; k++;
    end
    chk(name, 32'(acc_log.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk); #2; k++;
    end
    chk(name, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] bases[4];
    int base;
    int k;
    bases[0] = 32'hC0; bases[1] = 32'hD0; bases[2] = 32'hE0; bases[3] = 32'hF0;

    // Reset state
    tick(3);
    chk("t0_valid", 32'(out_if.out_valid), 32'd0);
    chk("t0_rd_req", 32'(fifo_rd_req), 32'd0);
    rstn = 1'b1;

    // Single row, one-row stripe
    tick(1);
    fifo_q.push_back(mkrow(32'hA0));
    force_empty = 1'b0;
    en = 1'b1;
    wait_done(1, 60, "t1_done_timeout");
    chk("t1_count", acc_log.size(), 32'd8);
    for (int i = 0; i < acc_log.size(); i++) begin
      chk("t1_data", acc_log[i].d, 32'hA0 + 32'(i));
      chk("t1_sop", 32'(acc_log[i].sop), 32'(i == 0));
      chk("t1_last", 32'(acc_log[i].last), 32'(i == 7));
    end
    if (acc_log.size() == 8) begin
      chk("t1_latency", acc_log[0].first_cyc - last_req_cyc, 32'd2);
      chk("t1_row_span", acc_log[7].first_cyc - acc_log[0].first_cyc, 32'd7);
    end

    // Backpressure 1,0,0,1
    acc_log.delete();
    ready_mode = 1;
    fifo_q.push_back(mkrow(32'hB0));
    wait_done(2, 100, "t2_done_timeout");
    chk("t2_count", acc_log.size(), 32'd8);
    for (int i = 0; i < acc_log.size(); i++) chk("t2_data", acc_log[i].d, 32'hB0 + 32'(i));
    ready_mode = 0;

    // Three-row stripe, fourth row opens a new stripe; m_val change mid-stripe
    acc_log.delete();
    m_val = 3'd3;
    base = req_cnt;
    for (int r = 0; r < 4; r++) fifo_q.push_back(mkrow(bases[r]));
    k = 0;
    while (req_cnt < base + 1 && k < 20) begin tick(1); k++; end
    chk("t3_first_req", 32'(req_cnt >= base + 1), 32'd1);
    m_val = 3'd2;
    wait_acc(32, 200, "t3_acc_timeout");
    for (int i = 0; i < acc_log.size(); i++) begin
      chk("t3_data", acc_log[i].d, bases[(i / 8) % 4] + 32'(i % 8));
      chk("t3_sop", 32'(acc_log[i].sop), 32'(i == 0 || i == 24));
      chk("t3_last", 32'(acc_log[i].last), 32'(i == 23));
    end
    tick(1);
    chk("t3_done_cnt", done_cnt, 32'd3);

    // FIFO empty: nothing is read
    force_empty = 1'b1;
    fifo_q.push_back(mkrow(32'h10));
    base = req_cnt;
    tick(10);
    chk("t4_no_req_empty", req_cnt, base);

    // Row closes the two-row stripe left open above
    acc_log.delete();
    force_empty = 1'b0;
    wait_done(4, 60, "t4_done_timeout");
    if (acc_log.size() == 8) begin
      chk("t4_g_sop", 32'(acc_log[0].sop), 32'd0);
      chk("t4_g_last", 32'(acc_log[7].last), 32'd1);
    end

    // Drop en during a row: the row finishes, no new read, stripe resumes afterwards
    fifo_q.push_back(mkrow(32'h20));
    fifo_q.push_back(mkrow(32'h30));
    k = 0;
    while (!out_if.out_valid && k < 20) begin tick(1); k++; end
    chk("t4_h_started", 32'(out_if.out_valid), 32'd1);
    en = 1'b0;
    base = req_cnt;
    wait_acc(16, 40, "t4_h_acc_timeout");
    tick(10);
    chk("t4_no_req_en_low", req_cnt, base);
    chk("t4_fifo_left", fifo_q.size(), 32'd1);
    if (acc_log.size() >= 16) begin
      chk("t4_h_sop", 32'(acc_log[8].sop), 32'd1);
      chk("t4_h_last", 32'(acc_log[15].last), 32'd0);
    end
    en = 1'b1;
    wait_done(5, 60, "t4_i_done_timeout");
    if (acc_log.size() >= 24) begin
      chk("t4_i_data0", acc_log[16].d, 32'h30);
      chk("t4_i_sop", 32'(acc_log[16].sop), 32'd0);
      chk("t4_i_last", 32'(acc_log[23].last), 32'd1);
    end

    // Reset in the middle of a row
    acc_log.delete();
    m_val = 3'd1;
    fifo_q.push_back(mkrow(32'h40));
    wait_acc(3, 40, "t5_acc_timeout");
    rstn = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_if.out_valid), 32'd0);
    chk("t5_async_data", out_if.out_data, 32'd0);
    tick(2);
    rstn = 1'b1;
    acc_log.delete();
    fifo_q.push_back(mkrow(32'h50));
    wait_done(6, 60, "t5_done_timeout");
    chk("t5_count", acc_log.size(), 32'd8);
    if (acc_log.size() == 8) begin
      chk("t5_sop", 32'(acc_log[0].sop), 32'd1);
      chk("t5_data0", acc_log[0].d, 32'h50);
      chk("t5_last", 32'(acc_log[7].last), 32'd1);
    end

    // Unexpected read data while idle
    en = 1'b0;
    force_empty = 1'b1;
    tick(2);
    chk("t6_err_before", 32'(err_unexp_val), 32'd0);
    inj_req++;
    tick(3);
    chk("t6_err_set", 32'(err_unexp_val), 32'd1);
    chk("t6_no_valid", 32'(out_if.out_valid), 32'd0);
    tick(5);
    chk("t6_err_sticky", 32'(err_unexp_val), 32'd1);
    chk("t6_no_beat", acc_log.size(), 32'd8);
    en = 1'b1;
    force_empty = 1'b0;
    fifo_q.push_back(mkrow(32'h60));
    wait_done(7, 60, "t6_done_timeout");
    if (acc_log.size() >= 9) begin
      chk("t6_next_sop", 32'(acc_log[8].sop), 32'd1);
      chk("t6_next_data", acc_log[8].d, 32'h60);
    end
    chk("t6_err_still", 32'(err_unexp_val), 32'd1);
    chk("model_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/eca_outbuf_reader.md
# eca_outbuf_reader

Drains finished parity rows from the output-buffer FIFO (sram_fifo read side) and serializes them onto a narrow user read stream with a valid/ready handshake. It sits between the output buffer and the user port, and is the read-side counterpart of the engine's write into that buffer. Each FIFO word holds one parity row of W packets. The block tracks rows per stripe against the configured parity count M and marks stripe boundaries for the user.

## Interface
Parameters:
- PACKET_LENGTH, 32, bits per packet.
- W, 8, packets per parity row (one FIFO word).
- OUT_DATA_W, 32, user read bus width; W*PACKET_LENGTH must be an integer multiple of it.
- M_MAX, 4, maximum parity rows per stripe.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  reader enable.
- m_val  in  $clog2(M_MAX+1)  parity rows per stripe, legal range 1..M_MAX.
- fifo_empty  in  1  output-buffer FIFO empty.
- fifo_rd_req  out  1  single-cycle read pulse to the FIFO.
- fifo_rd_data  in  W*PACKET_LENGTH  row word; packet i sits at bits [i*PACKET_LENGTH +: PACKET_LENGTH].
- fifo_rd_data_val  in  1  read data valid, exactly 1 cycle after fifo_rd_req.
- out_valid  out  1  beat valid.
- out_ready  in  1  user accepts beat.
- out_data  out  OUT_DATA_W  beat data.
- out_sop  out  1  first beat of a stripe.
- out_last  out  1  final beat of a stripe.
- stripe_done  out  1  one-cycle pulse after the final beat of a stripe is accepted.
- err_unexp_val  out  1  sticky; set when fifo_rd_data_val arrives with no read outstanding.

## Operation
- Beat count per row: BEATS = W*PACKET_LENGTH/OUT_DATA_W. Beats leave LSB-first, so beat 0 = bits [OUT_DATA_W-1:0].
- State machine: IDLE, WAIT, SEND.
- IDLE → WAIT when en=1 and fifo_empty=0. fifo_rd_req=1 for that single cycle.
- WAIT → SEND on fifo_rd_data_val. The word is captured into the shift register, beat_cnt=0.
- SEND: out_valid=1. On out_valid&out_ready the register shifts right by OUT_DATA_W and beat_cnt increments.
- SEND → IDLE when the beat with beat_cnt=BEATS-1 is accepted. row_cnt then increments, wrapping to 0 after m_lat-1.
- Stripe config: m_lat samples m_val on the IDLE→WAIT transition when row_cnt=0, and is held for the whole stripe. m_val=0 is treated as 1.
- out_sop=1 when row_cnt=0 and beat_cnt=0 in SEND.
- out_last=1 when row_cnt=m_lat-1 and beat_cnt=BEATS-1 in SEND.
- en=0: a row already in WAIT or SEND completes. No new read is issued. row_cnt is kept, so the stripe resumes when en returns to 1.
- fifo_rd_data_val in IDLE or SEND: data is ignored and err_unexp_val is set. Only reset clears it.

## Timing
- Reset values: fifo_rd_req=0, out_valid=0, out_data=0, out_sop=0, out_last=0, stripe_done=0, err_unexp_val=0. Internally state=IDLE, beat_cnt=0, row_cnt=0, m_lat=1.
- Latency: rd_req at cycle t, rd_data_val at t+1, out_valid first high at t+2.
- Row cost: BEATS+2 cycles without backpressure. The next rd_req can go out in the cycle after the last beat is accepted.
- Handshake: while out_valid=1 and out_ready=0, out_data, out_sop and out_last hold stable. out_valid never drops without an accept.
- stripe_done pulses in the cycle after out_last is accepted.
- At most one FIFO read is outstanding. fifo_empty is sampled only in IDLE.
- Reset mid-row: the row is discarded, outputs return to their reset values immediately (asynchronous), and row_cnt restarts at 0.

## Structure
- Shared package eca_pkg holds:
  - typedef rdr_state_t {IDLE, WAIT, SEND};
  - function beats_per_row(W, PACKET_LENGTH, OUT_DATA_W);
  - OUT_DATA_W default constant.
- Sub-module eca_row_serializer: load/shift register plus beat counter, with load, shift and last_beat signals.
- The top block keeps the FSM, the row/stripe counters and the error flag.
- Elaboration-time assertion: (W*PACKET_LENGTH)%OUT_DATA_W==0.

## Test plan
- Single row, M=1: FIFO word with packet i=32'hA0+i, out_ready=1. Expect:
  - 8 beats 0xA0..0xA7, starting 2 cycles after rd_req;
  - out_sop on beat 0, out_last on beat 7;
  - stripe_done 1 cycle after beat 7.
- Backpressure: out_ready toggles 1,0,0,1 repeating. Expect data, sop and last held stable while stalled; all 8 beats delivered in order with no loss or duplication.
- M=3 stripe, 4 rows queued. Expect:
  - out_sop only on row 0 beat 0, out_last only on row 2 beat 7;
  - the 4th row starts a new stripe with out_sop;
  - m_val changed to 2 mid-stripe has no effect until row_cnt=0.
- FIFO empty / en: with fifo_empty=1, no rd_req is issued. Dropping en during SEND lets the row finish with no further rd_req. Raising en again with row_cnt=1 continues the stripe.
- Reset mid-row: rstn low at beat 3 → out_valid=0 immediately. After release, the next row emits out_sop on beat 0.
- Unexpected valid: fifo_rd_data_val pulsed in IDLE → err_unexp_val=1 and stays set, no beat emitted, state stays IDLE.
